// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter
// Shares one memory read port between the instruction-side and the
// load/store-side page-table walkers. Only one access is outstanding at a
// time. Ties are broken round-robin. A flush or a timeout turns the
// outstanding access into a drop, which swallows the late read data.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   if_req_i / if_addr_i       IF walker read request and PTE address
//   if_rdata_o / if_rvalid_o   IF response data and one-cycle response pulse
//   if_err_o                   IF timeout error, pulsed together with if_rvalid_o
//   ls_*                       same set for the load/store walker
//   mem_req_o / mem_addr_o     shared memory request and address
//   mem_ready_i                memory accepts the request
//   mem_rdata_i / mem_rvalid_i memory read data and its valid strobe
//   mmu_flush_i                discard any in-flight walk response
//   busy_o                     an access is in progress
//   owner_o                    owner of the current/last access (0 IF, 1 LS)
module ptw_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_rvalid_o,
    output logic        if_err_o,
    input  logic        ls_req_i,
    input  logic [31:0] ls_addr_i,
    output logic [31:0] ls_rdata_o,
    output logic        ls_rvalid_o,
    output logic        ls_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rvalid_i,
    input  logic        mmu_flush_i,
    output logic        busy_o,
    output logic        owner_o
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             owner_q, owner_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      ls_rdata_q, ls_rdata_d;
    logic             if_rvalid_q, if_rvalid_d;
    logic             if_err_q, if_err_d;
    logic             ls_rvalid_q, ls_rvalid_d;
    logic             ls_err_q, ls_err_d;
    logic             grant_ls;
    logic             deliver;
    logic             timeout;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        owner_d     = owner_q;
        flush_d     = flush_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_err_d    = 1'b0;
        grant_ls    = 1'b0;
        deliver     = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush in IDLE only suppresses the grant for this cycle.
                if (!mmu_flush_i && (if_req_i || ls_req_i)) begin
                    // On a tie the requester that did not own the last access wins.
                    grant_ls = (if_req_i && ls_req_i) ? ~owner_q : ls_req_i;
                    owner_d  = grant_ls;
                    addr_d   = grant_ls ? ls_addr_i : if_addr_i;
                    flush_d  = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // The handshake is never withdrawn; a flush seen here is
                // remembered and applied once the memory accepts.
                if (mmu_flush_i) begin
                    flush_d = 1'b1;
                end
                if (mem_ready_i) begin
                    cnt_d   = '0;
                    state_d = (flush_q || mmu_flush_i) ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (mmu_flush_i) begin
                    // Data arriving with the flush is already the answer
                    // being discarded, so nothing is left to drop.
                    state_d = mem_rvalid_i ? IDLE : DROP;
                end else if (mem_rvalid_i) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TMO) begin
                        timeout = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (deliver) begin
            if (owner_q) begin
                ls_rdata_d  = mem_rdata_i;
                ls_rvalid_d = 1'b1;
            end else begin
                if_rdata_d  = mem_rdata_i;
                if_rvalid_d = 1'b1;
            end
        end

        if (timeout) begin
            if (owner_q) begin
                ls_rvalid_d = 1'b1;
                ls_err_d    = 1'b1;
            end else begin
                if_rvalid_d = 1'b1;
                if_err_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            owner_q     <= 1'b0;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            flush_q     <= flush_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_err_q    <= ls_err_d;
        end
    end

    assign mem_req_o   = (state_q == REQ);
    assign mem_addr_o  = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_rvalid_o = if_rvalid_q;
    assign if_err_o    = if_err_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_err_o    = ls_err_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Bench for ptw_mem_arbiter: a table of per-cycle vectors, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level
// reference model.
module tb_ptw_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        mmu_flush = 1'b0;

    logic [31:0] if_rdata_o, ls_rdata_o, mem_addr_o;
    logic        if_rvalid_o, if_err_o, ls_rvalid_o, ls_err_o;
    logic        mem_req_o, busy_o, owner_o;

    ptw_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata_o),
        .if_rvalid_o (if_rvalid_o),
        .if_err_o    (if_err_o),
        .ls_req_i    (ls_req),
        .ls_addr_i   (ls_addr),
        .ls_rdata_o  (ls_rdata_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_err_o    (ls_err_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready),
        .mem_rdata_i (mem_rdata),
        .mem_rvalid_i(mem_rvalid),
        .mmu_flush_i (mmu_flush),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one record describing the outstanding access.
    bit        m_active   = 1'b0; // an access exists (arbiter busy)
    bit        m_accepted = 1'b0; // memory has taken the request
    bit        m_doomed   = 1'b0; // its answer will be thrown away
    int        m_waited   = 0;    // cycles spent waiting for data
    bit        m_owner    = 1'b0;
    bit [31:0] m_addr     = '0;
    bit [31:0] m_ifd      = '0;
    bit [31:0] m_lsd      = '0;
    bit        m_ifrv = 1'b0, m_iferr = 1'b0, m_lsrv = 1'b0, m_lserr = 1'b0;

    typedef struct {
        logic [5:0]   c;   // {rst, if_req, ls_req, mem_ready, mem_rvalid, flush}
        logic [31:0]  ifa;
        logic [31:0]  lsa;
        logic [31:0]  rd;
        logic [102:0] exp;
    } vec_t;

    vec_t tbl[17];

    // Output image: {mem_req, mem_addr, busy, owner, if_rv, if_err, ls_rv, ls_err, if_rdata, ls_rdata}
    function automatic logic [102:0] pack(input logic [6:0] e, input logic [31:0] maddr,
                                          input logic [31:0] ifd, input logic [31:0] lsd);
        return {e[6], maddr, e[5:0], ifd, lsd};
    endfunction

    function automatic vec_t mk(input logic [5:0] c, input logic [31:0] ifa, input logic [31:0] lsa,
                                input logic [31:0] rd, input logic [6:0] e, input logic [31:0] maddr,
                                input logic [31:0] ifd, input logic [31:0] lsd);
        vec_t v;
        v.c   = c;
        v.ifa = ifa;
        v.lsa = lsa;
        v.rd  = rd;
        v.exp = pack(e, maddr, ifd, lsd);
        return v;
    endfunction

    function automatic logic [102:0] dut_vec();
        return {mem_req_o, mem_addr_o, busy_o, owner_o, if_rvalid_o, if_err_o,
                ls_rvalid_o, ls_err_o, if_rdata_o, ls_rdata_o};
    endfunction

    function automatic logic [102:0] model_vec();
        return {m_active && !m_accepted, m_addr, m_active, m_owner, m_ifrv, m_iferr,
                m_lsrv, m_lserr, m_ifd, m_lsd};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] c, input logic [31:0] ifa, input logic [31:0] lsa,
                         input logic [31:0] rd);
        rst        = c[5];
        if_req     = c[4];
        ls_req     = c[3];
        mem_ready  = c[2];
        mem_rvalid = c[1];
        mmu_flush  = c[0];
        if_addr    = ifa;
        ls_addr    = lsa;
        mem_rdata  = rd;
    endtask

    // Advance the model by one clock using the inputs the DUT is about to see.
    task automatic model_step();
        m_ifrv  = 1'b0;
        m_iferr = 1'b0;
        m_lsrv  = 1'b0;
        m_lserr = 1'b0;
        if (rst) begin
            m_active   = 1'b0;
            m_accepted = 1'b0;
            m_doomed   = 1'b0;
            m_waited   = 0;
            m_owner    = 1'b0;
            m_addr     = '0;
            m_ifd      = '0;
            m_lsd      = '0;
        end else if (!m_active) begin
            if (!mmu_flush && (if_req || ls_req)) begin
                m_owner    = (if_req && ls_req) ? !m_owner : ls_req;
                m_addr     = m_owner ? ls_addr : if_addr;
                m_active   = 1'b1;
                m_accepted = 1'b0;
                m_doomed   = 1'b0;
            end
        end else if (!m_accepted) begin
            if (mmu_flush) m_doomed = 1'b1;
            if (mem_ready) begin
                m_accepted = 1'b1;
                m_waited   = 0;
            end
        end else if (m_doomed) begin
            if (mem_rvalid) m_active = 1'b0;
        end else if (mmu_flush) begin
            if (mem_rvalid) m_active = 1'b0;
            else            m_doomed = 1'b1;
        end else if (mem_rvalid) begin
            if (m_owner) begin m_lsd = mem_rdata; m_lsrv = 1'b1; end
            else         begin m_ifd = mem_rdata; m_ifrv = 1'b1; end
            m_active = 1'b0;
        end else begin
            m_waited++;
            if (m_waited == TMO) begin
                if (m_owner) begin m_lsrv = 1'b1; m_lserr = 1'b1; end
                else         begin m_ifrv = 1'b1; m_iferr = 1'b1; end
                m_doomed = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single IF request, then reset, then ties alternating LS, IF, LS.
        tbl[0]  = mk(6'b100000, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h0);
        tbl[1]  = mk(6'b010000, 32'h80001000, 32'h0, 32'h0, 7'b1100000, 32'h80001000, 32'h0, 32'h0);
        tbl[2]  = mk(6'b010100, 32'h80001000, 32'h0, 32'h0, 7'b0100000, 32'h80001000, 32'h0, 32'h0);
        tbl[3]  = mk(6'b010000, 32'h80001000, 32'h0, 32'h0, 7'b0100000, 32'h80001000, 32'h0, 32'h0);
        tbl[4]  = mk(6'b010000, 32'h80001000, 32'h0, 32'h0, 7'b0100000, 32'h80001000, 32'h0, 32'h0);
        tbl[5]  = mk(6'b010010, 32'h80001000, 32'h0, 32'h20000CF1, 7'b0001000, 32'h80001000, 32'h20000CF1, 32'h0);
        tbl[6]  = mk(6'b100000, 32'h0, 32'h0, 32'h0, 7'b0000000, 32'h0, 32'h0, 32'h0);
        tbl[7]  = mk(6'b011000, 32'h100, 32'h200, 32'h0, 7'b1110000, 32'h200, 32'h0, 32'h0);
        tbl[8]  = mk(6'b011100, 32'h100, 32'h200, 32'h0, 7'b0110000, 32'h200, 32'h0, 32'h0);
        tbl[9]  = mk(6'b011010, 32'h100, 32'h200, 32'hAAAA5555, 7'b0010010, 32'h200, 32'h0, 32'hAAAA5555);
        tbl[10] = mk(6'b011000, 32'h100, 32'h200, 32'h0, 7'b1100000, 32'h100, 32'h0, 32'hAAAA5555);
        tbl[11] = mk(6'b011100, 32'h100, 32'h200, 32'h0, 7'b0100000, 32'h100, 32'h0, 32'hAAAA5555);
        tbl[12] = mk(6'b011010, 32'h100, 32'h200, 32'h12345678, 7'b0001000, 32'h100, 32'h12345678, 32'hAAAA5555);
        tbl[13] = mk(6'b011000, 32'h100, 32'h200, 32'h0, 7'b1110000, 32'h200, 32'h12345678, 32'hAAAA5555);
        tbl[14] = mk(6'b000100, 32'h0, 32'h0, 32'h0, 7'b0110000, 32'h200, 32'h12345678, 32'hAAAA5555);
        tbl[15] = mk(6'b000010, 32'h0, 32'h0, 32'h0BADF00D, 7'b0010010, 32'h200, 32'h12345678, 32'h0BADF00D);
        tbl[16] = mk(6'b000000, 32'h0, 32'h0, 32'h0, 7'b0010000, 32'h200, 32'h12345678, 32'h0BADF00D);

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].c, tbl[i].ifa, tbl[i].lsa, tbl[i].rd);
            cycle();
            chk($sformatf("table[%0d]", i), 128'(dut_vec()), 128'(tbl[i].exp));
        end

        // Backpressure: request and address hold through a stall; a flush
        // during the stall keeps mem_req_o up and later drops the data.
        drive(6'b010000, 32'hCAFE0000, 32'h0, 32'h0);
        cycle();
        chk("bp_grant", 128'({mem_req_o, mem_addr_o}), 128'({1'b1, 32'hCAFE0000}));
        for (int k = 0; k < 5; k++) begin
            drive({5'b00000, (k == 1)}, 32'h0, 32'h0, 32'h0);
            cycle();
            chk("bp_stall", 128'({mem_req_o, mem_addr_o}), 128'({1'b1, 32'hCAFE0000}));
        end
        drive(6'b000100, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("bp_drop", 128'({busy_o, mem_req_o}), 128'(2'b10));
        drive(6'b000000, 32'h0, 32'h0, 32'h0);
        cycle();
        cycle();
        chk("bp_drop_hold", 128'({busy_o, mem_req_o}), 128'(2'b10));
        drive(6'b000010, 32'h0, 32'h0, 32'hDEADBEEF);
        cycle();
        chk("bp_discard", 128'({busy_o, if_rvalid_o, ls_rvalid_o, if_rdata_o}),
            128'({3'b000, 32'h12345678}));

        // Flush one cycle after the handshake.
        drive(6'b001000, 32'h0, 32'h3000, 32'h0);
        cycle();
        chk("fl_grant", 128'({mem_req_o, owner_o, mem_addr_o}), 128'({2'b11, 32'h3000}));
        drive(6'b000100, 32'h0, 32'h0, 32'h0);
        cycle();
        drive(6'b000001, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("fl_drop", 128'({busy_o, mem_req_o}), 128'(2'b10));
        drive(6'b000000, 32'h0, 32'h0, 32'h0);
        cycle();
        drive(6'b000010, 32'h0, 32'h0, 32'h00000055);
        cycle();
        chk("fl_discard", 128'({busy_o, ls_rvalid_o, ls_err_o, ls_rdata_o}),
            128'({3'b000, 32'h0BADF00D}));
        drive(6'b000000, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("fl_quiet", 128'({busy_o, ls_rvalid_o, if_rvalid_o}), 128'(3'b000));

        // Timeout on the LS side, then a late answer is swallowed.
        drive(6'b001000, 32'h0, 32'h4000, 32'h0);
        cycle();
        chk("to_grant", 128'({mem_req_o, owner_o, mem_addr_o}), 128'({2'b11, 32'h4000}));
        drive(6'b000100, 32'h0, 32'h0, 32'h0);
        cycle();
        drive(6'b000000, 32'h0, 32'h0, 32'h0);
        for (int w = 1; w <= 4; w++) begin
            cycle();
            chk($sformatf("to_wait%0d", w),
                128'({ls_rvalid_o, ls_err_o, if_rvalid_o, if_err_o, ls_rdata_o}),
                128'({(w == 4), (w == 4), 2'b00, 32'h0BADF00D}));
        end
        cycle();
        chk("to_pulse_end", 128'({busy_o, ls_rvalid_o, ls_err_o}), 128'(3'b100));
        for (int k = 0; k < 9; k++) cycle();
        chk("to_drop_hold", 128'({busy_o, mem_req_o}), 128'(2'b10));
        drive(6'b000010, 32'h0, 32'h0, 32'h00000099);
        cycle();
        chk("to_late", 128'({busy_o, ls_rvalid_o, ls_err_o, ls_rdata_o}),
            128'({3'b000, 32'h0BADF00D}));

        // Reset in the middle of WAIT abandons the access.
        drive(6'b010000, 32'h5000, 32'h0, 32'h0);
        cycle();
        drive(6'b000100, 32'h0, 32'h0, 32'h0);
        cycle();
        drive(6'b000000, 32'h0, 32'h0, 32'h0);
        cycle();
        drive(6'b100000, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("rst_mid", 128'(dut_vec()), 128'(0));
        drive(6'b000010, 32'h0, 32'h0, 32'h00000077);
        cycle();
        chk("rst_late", 128'(dut_vec()), 128'(0));
        drive(6'b000000, 32'h0, 32'h0, 32'h0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive({($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0)},
                  $urandom, $urandom, $urandom);
            cycle();
            chk("rand", 128'(dut_vec()), 128'(model_vec()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
